mem_port_arbiter: RTL and testbench

- Shares one single-ported, byte-addressed memory between two requesters: the instruction-fetch port and the data (load/store/call/return) port of the five-stage tinker core.
- Allows one outstanding memory transaction at a time.
- Uses data-priority arbitration with a starvation guard, so fetch cannot be locked out by a stream of loads and stores.
- Sits between the core's IF/MEM stages and the memory; the core stalls on each port until that port's response pulse.

---
 rtl/tinker_mem_pkg.sv | 25 ++
 rtl/mem_arb_pick.sv | 25 ++
 rtl/mem_port_arbiter.sv | 162 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tinker_mem_pkg.sv
// ============================================================================
//  Module : tinker_mem_pkg
//  Brief  : Shared types and defaults for the tinker core memory-port arbiter.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package tinker_mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_t;

    typedef enum logic {
        SRC_IF = 1'b0,
        SRC_D  = 1'b1
    } src_t;

    localparam int c_default_max_streak = 4;

endpackage

`default_nettype wire

// File: rtl/mem_arb_pick.sv
// ============================================================================
//  Module : mem_arb_pick
//  Brief  : Combinational data-priority pick with a fetch starvation override.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_arb_pick
    import tinker_mem_pkg::*;
(
    input  logic if_req,
    input  logic d_req,
    input  logic streak_full,
    output logic grant_valid,
    output src_t grant_src
);

    always_comb begin
        grant_valid = if_req | d_req;
        grant_src   = (d_req && !(if_req && streak_full)) ? SRC_D : SRC_IF;
    end

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
//  Module : mem_port_arbiter
//  Brief  : Shares one single-ported memory between fetch and data ports,
//           one outstanding transaction, data priority with streak guard.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter
    import tinker_mem_pkg::*;
#(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 64,
    parameter int MAX_STREAK = c_default_max_streak
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int                 STREAK_W     = 4;
    localparam logic [STREAK_W-1:0] c_streak_max = STREAK_W'(MAX_STREAK);

    arb_state_t          state_q, state_d;
    src_t                src_q, src_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [STREAK_W-1:0] streak_q, streak_d;
    logic [31:0]         if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
    logic                mem_valid_q, mem_valid_d;
    logic                busy_q, busy_d;

    logic                grant_valid;
    src_t                grant_src;
    logic                fire;

    mem_arb_pick u_pick (
        .if_req      (if_req),
        .d_req       (d_req),
        .streak_full (streak_q == c_streak_max),
        .grant_valid (grant_valid),
        .grant_src   (grant_src)
    );

    assign fire = (state_q == WAIT) && mem_rvalid;

    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        streak_d   = streak_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;

        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    state_d = ISSUE;
                    src_d   = grant_src;
                    if (grant_src == SRC_D) begin
                        we_d    = d_we;
                        addr_d  = d_addr;
                        wdata_d = d_wdata;
                        // Only a D win over a waiting fetch counts toward starvation.
                        if (!if_req) begin
                            streak_d = '0;
                        end else if (streak_q != c_streak_max) begin
                            streak_d = streak_q + STREAK_W'(1);
                        end
                    end else begin
                        we_d     = 1'b0;
                        addr_d   = if_addr;
                        wdata_d  = '0;
                        streak_d = '0;
                    end
                end
            end
            ISSUE: begin
                if (mem_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    state_d = IDLE;
                    if (src_q == SRC_IF) begin
                        if_rdata_d = mem_rdata[31:0];
                    end else begin
                        d_rdata_d = mem_rdata;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        mem_valid_d = (state_d == ISSUE);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            src_q       <= SRC_IF;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            streak_q    <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            mem_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            src_q       <= src_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            streak_q    <= streak_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            mem_valid_q <= mem_valid_d;
            busy_q      <= busy_d;
        end
    end

    // Response data is forwarded in the completion cycle and held afterwards.
    assign if_rvalid = fire && (src_q == SRC_IF);
    assign d_rvalid  = fire && (src_q == SRC_D);
    assign if_rdata  = if_rdata_d;
    assign d_rdata   = d_rdata_d;
    assign mem_valid = mem_valid_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign busy      = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
//  Module : tb_mem_port_arbiter
//  Brief  : Scoreboard bench for mem_port_arbiter with a behavioural memory.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

    typedef struct {
        logic        we;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] rdata;
    } txn_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, if_rvalid, d_req, d_we, d_rvalid;
    logic [63:0] if_addr, d_addr, d_wdata, d_rdata;
    logic [31:0] if_rdata;
    logic        mem_valid, mem_ready, mem_we, mem_rvalid, busy;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;

    mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .MAX_STREAK(4)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    txn_t if_stim[$], d_stim[$], exp_if[$], exp_d[$], exp_acc[$];
    logic if_got, d_got;
    int   if_issue_cyc, if_rv_cyc, d_rv_cyc, first_v_cyc, acc_cyc;
    int   vcount = 0, addr_bad = 0, n_if = 0, n_d = 0;
    logic [63:0] vaddr;

    logic [63:0] mem_arr [logic [63:0]];
    int   stall = 0, rv_delay = 0, cnt = 0;
    bit   pend = 0, spur = 0;
    txn_t cur;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic txn_t mk(input logic we, input logic [63:0] a, input logic [63:0] w,
                                input logic [63:0] r);
        txn_t t;
        t.we = we; t.addr = a; t.wdata = w; t.rdata = r;
        return t;
    endfunction

    // Fetch requester: holds request and address until its response pulse.
    initial begin
        txn_t t;
        if_req = 1'b0; if_addr = '0; if_got = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (reset) begin
                if_req = 1'b0; if_got = 1'b0;
            end else begin
                if (if_req && if_got) begin if_req = 1'b0; if_got = 1'b0; end
                if (!if_req && if_stim.size() > 0) begin
                    t = if_stim.pop_front();
                    if_addr = t.addr; if_req = 1'b1; if_issue_cyc = cyc;
                    exp_if.push_back(t);
                end
            end
        end
    end

    // Data requester.
    initial begin
        txn_t t;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_got = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (reset) begin
                d_req = 1'b0; d_got = 1'b0;
            end else begin
                if (d_req && d_got) begin d_req = 1'b0; d_got = 1'b0; end
                if (!d_req && d_stim.size() > 0) begin
                    t = d_stim.pop_front();
                    d_we = t.we; d_addr = t.addr; d_wdata = t.wdata; d_req = 1'b1;
                    exp_d.push_back(t);
                end
            end
        end
    end

    // Behavioural memory: programmable ready stall and completion delay.
    initial begin
        txn_t e;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        forever begin
            @(negedge clk);
            mem_rvalid = 1'b0;
            if (reset) begin
                pend = 0; mem_ready = 1'b0;
            end else if (spur) begin
                mem_rvalid = 1'b1; mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF; spur = 0;
            end else if (pend) begin
                mem_ready = 1'b0;
                if (cnt == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata = cur.we ? 64'h0 :
                                (mem_arr.exists(cur.addr) ? mem_arr[cur.addr] : 64'h0);
                    pend = 0;
                end else begin
                    cnt--;
                end
            end else if (mem_valid) begin
                if (stall > 0) begin
                    mem_ready = 1'b0; stall--;
                end else begin
                    mem_ready = 1'b1;
                    cur = mk(mem_we, mem_addr, mem_wdata, 64'h0);
                    acc_cyc = cyc;
                    if (exp_acc.size() == 0) begin
                        check("acc_unexpected", 64'(mem_valid), 64'd0);
                    end else begin
                        e = exp_acc.pop_front();
                        check("acc_we", 64'(mem_we), 64'(e.we));
                        check("acc_addr", mem_addr, e.addr);
                        if (e.we) check("acc_wdata", mem_wdata, e.wdata);
                    end
                    if (mem_we) mem_arr[mem_addr] = mem_wdata;
                    pend = 1; cnt = rv_delay;
                end
            end else begin
                mem_ready = 1'b0;
            end
        end
    end

    // Response monitor.
    initial begin
        txn_t e;
        forever begin
            @(negedge clk); #2;
            if (!reset) begin
                if (mem_valid) begin
                    if (vcount == 0) begin first_v_cyc = cyc; vaddr = mem_addr; end
                    else if (mem_addr !== vaddr) addr_bad++;
                    vcount++;
                end
                if (if_rvalid) begin
                    if_rv_cyc = cyc; n_if++;
                    if (exp_if.size() == 0) check("if_rvalid_unexpected", 64'(if_rvalid), 64'd0);
                    else begin
                        e = exp_if.pop_front();
                        check("if_rdata", 64'(if_rdata), 64'(e.rdata[31:0]));
                        if_got = 1'b1;
                    end
                end
                if (d_rvalid) begin
                    d_rv_cyc = cyc; n_d++;
                    if (exp_d.size() == 0) check("d_rvalid_unexpected", 64'(d_rvalid), 64'd0);
                    else begin
                        e = exp_d.pop_front();
                        if (!e.we) check("d_rdata", d_rdata, e.rdata);
                        d_got = 1'b1;
                    end
                end
            end
        end
    end

    task automatic wait_done(input string name, input int budget);
        bit ok;
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk); #3;
            if (if_stim.size() == 0 && d_stim.size() == 0 && exp_if.size() == 0 &&
                exp_d.size() == 0 && exp_acc.size() == 0 && !if_req && !d_req && !busy) begin
                ok = 1;
                break;
            end
        end
        check({"done_", name}, 64'(ok), 64'd1);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_mem_valid"}, 64'(mem_valid), 64'd0);
        check({tag, "_mem_we"}, 64'(mem_we), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_if_rvalid"}, 64'(if_rvalid), 64'd0);
        check({tag, "_d_rvalid"}, 64'(d_rvalid), 64'd0);
        check({tag, "_mem_addr"}, mem_addr, 64'd0);
        check({tag, "_mem_wdata"}, mem_wdata, 64'd0);
        check({tag, "_if_rdata"}, 64'(if_rdata), 64'd0);
        check({tag, "_d_rdata"}, d_rdata, 64'd0);
    endtask

    initial begin
        #100000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        int n0, nif0;
        bit ok;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk); #3;
        check_zero("reset");
        reset = 1'b0;

        mem_arr[64'h2000] = 64'h0000_0000_1234_5678;
        mem_arr[64'h3000] = 64'h1111_0000_C0DE_0001;
        mem_arr[64'h3004] = 64'h2222_0000_C0DE_0002;
        for (int i = 1; i <= 9; i++) mem_arr[64'h400 + 64'(8 * i)] = 64'hD000_0000_0000_0000 | 64'(i);
        mem_arr[64'h500] = 64'h5555_AAAA_5555_AAAA;
        mem_arr[64'h600] = 64'h6666_6666_6666_6666;

        // Fetch only, completion one cycle after acceptance.
        @(negedge clk);
        rv_delay = 1; vcount = 0; n0 = n_d;
        exp_acc.push_back(mk(1'b0, 64'h2000, 64'h0, 64'h0));
        if_stim.push_back(mk(1'b0, 64'h2000, 64'h0, 64'h0000_0000_1234_5678));
        wait_done("fetch", 40);
        check("fetch_valid_latency", 64'(first_v_cyc - if_issue_cyc), 64'd1);
        check("fetch_rvalid_latency", 64'(if_rv_cyc - if_issue_cyc), 64'd3);
        check("fetch_valid_cycles", 64'(vcount), 64'd1);
        check("fetch_no_d_rvalid", 64'(n_d - n0), 64'd0);

        // Store then load of the same address.
        rv_delay = 0;
        exp_acc.push_back(mk(1'b1, 64'h100, 64'hDEAD_BEEF, 64'h0));
        exp_acc.push_back(mk(1'b0, 64'h100, 64'h0, 64'h0));
        d_stim.push_back(mk(1'b1, 64'h100, 64'hDEAD_BEEF, 64'h0));
        d_stim.push_back(mk(1'b0, 64'h100, 64'h0, 64'hDEAD_BEEF));
        wait_done("store_load", 40);
        check("load_d_rdata_hold", d_rdata, 64'hDEAD_BEEF);

        // Contention: four D grants, then fetch, streak restarts, alone D at the end.
        for (int i = 1; i <= 4; i++) exp_acc.push_back(mk(1'b0, 64'h400 + 64'(8 * i), 64'h0, 64'h0));
        exp_acc.push_back(mk(1'b0, 64'h3000, 64'h0, 64'h0));
        for (int i = 5; i <= 8; i++) exp_acc.push_back(mk(1'b0, 64'h400 + 64'(8 * i), 64'h0, 64'h0));
        exp_acc.push_back(mk(1'b0, 64'h3004, 64'h0, 64'h0));
        exp_acc.push_back(mk(1'b0, 64'h448, 64'h0, 64'h0));
        if_stim.push_back(mk(1'b0, 64'h3000, 64'h0, 64'h0000_0000_C0DE_0001));
        if_stim.push_back(mk(1'b0, 64'h3004, 64'h0, 64'h0000_0000_C0DE_0002));
        for (int i = 1; i <= 9; i++)
            d_stim.push_back(mk(1'b0, 64'h400 + 64'(8 * i), 64'h0, 64'hD000_0000_0000_0000 | 64'(i)));
        wait_done("contention", 120);

        // Backpressure: five stalled ISSUE cycles.
        stall = 5; vcount = 0; addr_bad = 0;
        exp_acc.push_back(mk(1'b0, 64'h500, 64'h0, 64'h0));
        d_stim.push_back(mk(1'b0, 64'h500, 64'h0, 64'h5555_AAAA_5555_AAAA));
        wait_done("backpressure", 40);
        check("bp_valid_cycles", 64'(vcount), 64'd6);
        check("bp_addr_stable", 64'(addr_bad), 64'd0);
        check("bp_accept_cycle", 64'(acc_cyc - first_v_cyc), 64'd5);
        check("bp_rvalid_cycle", 64'(d_rv_cyc - acc_cyc), 64'd1);

        // Reset with a load outstanding in WAIT.
        rv_delay = 4;
        exp_acc.push_back(mk(1'b0, 64'h600, 64'h0, 64'h0));
        d_stim.push_back(mk(1'b0, 64'h600, 64'h0, 64'h6666_6666_6666_6666));
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #3;
            if (busy && !mem_valid && exp_acc.size() == 0) begin ok = 1; break; end
        end
        check("reach_wait", 64'(ok), 64'd1);
        reset = 1'b1;
        #1;
        check_zero("midreset");
        exp_d.delete(); d_stim.delete(); exp_acc.delete();
        n0 = n_d; nif0 = n_if;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        spur = 1;
        repeat (3) @(negedge clk);
        #3;
        check("postreset_no_d_rvalid", 64'(n_d - n0), 64'd0);
        check("postreset_no_if_rvalid", 64'(n_if - nif0), 64'd0);
        check("postreset_busy", 64'(busy), 64'd0);
        check("postreset_d_rdata", d_rdata, 64'd0);

        // Recovery fetch, then a spurious completion in IDLE.
        rv_delay = 0;
        exp_acc.push_back(mk(1'b0, 64'h2000, 64'h0, 64'h0));
        if_stim.push_back(mk(1'b0, 64'h2000, 64'h0, 64'h0000_0000_1234_5678));
        wait_done("recovery_fetch", 40);
        n0 = n_d; nif0 = n_if;
        spur = 1;
        repeat (3) @(negedge clk);
        #3;
        check("spur_no_if_rvalid", 64'(n_if - nif0), 64'd0);
        check("spur_no_d_rvalid", 64'(n_d - n0), 64'd0);
        check("spur_if_rdata_hold", 64'(if_rdata), 64'h1234_5678);
        check("spur_busy", 64'(busy), 64'd0);
        check("spur_mem_valid", 64'(mem_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
